// File: rtl/cpwm_irq_ctrl_pkg.sv
// Shared types and defaults for the carrier-PWM interrupt controller.
// Holds the pulse FSM state encoding and the irq_mode encodings.
package cpwm_irq_ctrl_pkg;

    localparam int PWM_WIDTH_DEF = 8;
    localparam int PULSE_LEN_DEF = 4;
    localparam int CNT_W_DEF     = 16;

    localparam logic IRQ_MODE_LEVEL = 1'b0;
    localparam logic IRQ_MODE_PULSE = 1'b1;

    typedef enum logic [1:0] {
        IRQ_IDLE  = 2'd0,
        IRQ_PULSE = 2'd1,
        IRQ_GAP   = 2'd2
    } irq_state_t;

endpackage

// File: rtl/cpwm_irq_ctrl_if.sv
// Register-file side bundle of the interrupt controller.
// master = AXI4-Lite register file, slave = cpwm_irq_ctrl.
interface cpwm_irq_ctrl_if #(
    parameter int PWM_WIDTH = 8,
    parameter int CNT_W     = 16
);
    logic [PWM_WIDTH-1:0] irq_in;
    logic                 irq_en;
    logic                 irq_mode;
    logic [15:0]          holdoff;
    logic                 clr_valid;
    logic [PWM_WIDTH-1:0] clr_mask;
    logic                 cnt_clr;
    logic [PWM_WIDTH-1:0] status;
    logic [PWM_WIDTH-1:0] overrun;
    logic [CNT_W-1:0]     event_cnt;
    logic                 irq_out;
    logic                 irq_busy;

    modport master (
        output irq_in, irq_en, irq_mode, holdoff, clr_valid, clr_mask, cnt_clr,
        input  status, overrun, event_cnt, irq_out, irq_busy
    );

    modport slave (
        input  irq_in, irq_en, irq_mode, holdoff, clr_valid, clr_mask, cnt_clr,
        output status, overrun, event_cnt, irq_out, irq_busy
    );

endinterface

// File: rtl/cpwm_irq_ctrl_pulse_fsm.sv
// Pulse-mode interrupt generator: fixed-width pulse, programmable hold-off,
// at most one coalesced pending request.
module cpwm_irq_pulse_fsm
    import cpwm_irq_ctrl_pkg::*;
#(
    parameter int PULSE_LEN = PULSE_LEN_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        any_edge,
    input  logic        irq_en,
    input  logic        irq_mode,
    input  logic [15:0] holdoff,
    output logic        pulse,
    output logic        busy
);

    localparam logic [15:0] PULSE_LOAD = 16'(PULSE_LEN - 1);

    irq_state_t  state_r;
    logic [15:0] cnt_r;
    logic        pending_r;
    logic        mode_r;
    logic        pulse_r;
    logic        busy_r;
    logic        force_idle_s;
    logic        req_s;

    // Disable, level mode or a mode change all abort any activity.
    assign force_idle_s = ~irq_en | (irq_mode != mode_r) | (irq_mode == IRQ_MODE_LEVEL);
    assign req_s        = pending_r | any_edge;

    // State, hold counter, pending flag and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IRQ_IDLE;
            cnt_r     <= 16'd0;
            pending_r <= 1'b0;
            mode_r    <= IRQ_MODE_LEVEL;
            pulse_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            mode_r <= irq_mode;
            if (force_idle_s) begin
                state_r   <= IRQ_IDLE;
                cnt_r     <= 16'd0;
                pending_r <= 1'b0;
                pulse_r   <= 1'b0;
                busy_r    <= 1'b0;
            end else begin
                case (state_r)
                    IRQ_IDLE: begin
                        if (any_edge) begin
                            state_r <= IRQ_PULSE;
                            cnt_r   <= PULSE_LOAD;
                            pulse_r <= 1'b1;
                            busy_r  <= 1'b1;
                        end else begin
                            cnt_r   <= 16'd0;
                            pulse_r <= 1'b0;
                            busy_r  <= 1'b0;
                        end
                        pending_r <= 1'b0;
                    end
                    IRQ_PULSE: begin
                        if (cnt_r != 16'd0) begin
                            cnt_r     <= cnt_r - 16'd1;
                            pending_r <= req_s;
                            pulse_r   <= 1'b1;
                            busy_r    <= 1'b1;
                        end else if (holdoff != 16'd0) begin
                            state_r   <= IRQ_GAP;
                            cnt_r     <= holdoff - 16'd1;
                            pending_r <= req_s;
                            pulse_r   <= 1'b0;
                            busy_r    <= 1'b1;
                        end else if (req_s) begin
                            // Zero hold-off: back-to-back pulse for the coalesced request.
                            cnt_r     <= PULSE_LOAD;
                            pending_r <= 1'b0;
                            pulse_r   <= 1'b1;
                            busy_r    <= 1'b1;
                        end else begin
                            state_r   <= IRQ_IDLE;
                            pending_r <= 1'b0;
                            pulse_r   <= 1'b0;
                            busy_r    <= 1'b0;
                        end
                    end
                    IRQ_GAP: begin
                        if (cnt_r != 16'd0) begin
                            cnt_r     <= cnt_r - 16'd1;
                            pending_r <= req_s;
                            pulse_r   <= 1'b0;
                            busy_r    <= 1'b1;
                        end else if (req_s) begin
                            state_r   <= IRQ_PULSE;
                            cnt_r     <= PULSE_LOAD;
                            pending_r <= 1'b0;
                            pulse_r   <= 1'b1;
                            busy_r    <= 1'b1;
                        end else begin
                            state_r   <= IRQ_IDLE;
                            pending_r <= 1'b0;
                            pulse_r   <= 1'b0;
                            busy_r    <= 1'b0;
                        end
                    end
                    default: begin
                        state_r   <= IRQ_IDLE;
                        cnt_r     <= 16'd0;
                        pending_r <= 1'b0;
                        pulse_r   <= 1'b0;
                        busy_r    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pulse = pulse_r;
    assign busy  = busy_r;

endmodule

// File: rtl/cpwm_irq_ctrl.sv
// Interrupt aggregation for the 8-channel carrier PWM: edge detect, sticky W1C
// status/overrun, saturating event counter and the PS interrupt line.
module cpwm_irq_ctrl
    import cpwm_irq_ctrl_pkg::*;
#(
    parameter int PWM_WIDTH = PWM_WIDTH_DEF,
    parameter int PULSE_LEN = PULSE_LEN_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    cpwm_irq_ctrl_if.slave regs
);

    localparam int PC_W = $clog2(PWM_WIDTH + 1);

    function automatic logic [PC_W-1:0] popcount(input logic [PWM_WIDTH-1:0] v);
        logic [PC_W-1:0] n;
        n = {PC_W{1'b0}};
        for (int i = 0; i < PWM_WIDTH; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    logic [PWM_WIDTH-1:0] irq_in_d_r;
    logic [PWM_WIDTH-1:0] status_r;
    logic [PWM_WIDTH-1:0] overrun_r;
    logic [CNT_W-1:0]     event_cnt_r;
    logic                 level_r;
    logic [PWM_WIDTH-1:0] acc_edge_s;
    logic [PWM_WIDTH-1:0] clr_s;
    logic [PWM_WIDTH-1:0] status_next_s;
    logic [PWM_WIDTH-1:0] overrun_next_s;
    logic [PC_W-1:0]      edge_cnt_s;
    logic [CNT_W:0]       cnt_sum_s;
    logic [CNT_W-1:0]     cnt_next_s;
    logic                 any_edge_s;
    logic                 pulse_s;
    logic                 busy_s;

    // Next-state of sticky bits and counter; a set always beats a same-cycle clear.
    always_comb begin
        acc_edge_s     = regs.irq_in & ~irq_in_d_r & {PWM_WIDTH{regs.irq_en}};
        clr_s          = regs.clr_valid ? regs.clr_mask : {PWM_WIDTH{1'b0}};
        status_next_s  = (status_r & ~clr_s) | acc_edge_s;
        overrun_next_s = (overrun_r & ~clr_s) | (acc_edge_s & status_r);
        any_edge_s     = |acc_edge_s;
        edge_cnt_s     = popcount(acc_edge_s);
        cnt_sum_s      = {1'b0, event_cnt_r} + (CNT_W + 1)'(edge_cnt_s);
        if (regs.cnt_clr) begin
            cnt_next_s = CNT_W'(edge_cnt_s);
        end else if (cnt_sum_s[CNT_W]) begin
            cnt_next_s = {CNT_W{1'b1}};
        end else begin
            cnt_next_s = cnt_sum_s[CNT_W-1:0];
        end
    end

    // Edge history, sticky registers, counter and level-mode interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_in_d_r  <= {PWM_WIDTH{1'b0}};
            status_r    <= {PWM_WIDTH{1'b0}};
            overrun_r   <= {PWM_WIDTH{1'b0}};
            event_cnt_r <= {CNT_W{1'b0}};
            level_r     <= 1'b0;
        end else begin
            irq_in_d_r  <= regs.irq_in;
            status_r    <= status_next_s;
            overrun_r   <= overrun_next_s;
            event_cnt_r <= cnt_next_s;
            level_r     <= (regs.irq_mode == IRQ_MODE_LEVEL) & regs.irq_en & (|status_next_s);
        end
    end

    cpwm_irq_pulse_fsm #(
        .PULSE_LEN (PULSE_LEN)
    ) u_pulse_fsm (
        .clk      (clk),
        .reset    (reset),
        .any_edge (any_edge_s),
        .irq_en   (regs.irq_en),
        .irq_mode (regs.irq_mode),
        .holdoff  (regs.holdoff),
        .pulse    (pulse_s),
        .busy     (busy_s)
    );

    // The FSM keeps pulse low in level mode, so both sources are simply merged.
    assign regs.irq_out   = pulse_s | level_r;
    assign regs.irq_busy  = busy_s;
    assign regs.status    = status_r;
    assign regs.overrun   = overrun_r;
    assign regs.event_cnt = event_cnt_r;

endmodule

// File: tb/tb_cpwm_irq_ctrl.sv
// Self-checking bench for cpwm_irq_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a timeline-based reference model.
module tb_cpwm_irq_ctrl;

    localparam int PW    = 8;
    localparam int PLEN  = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    cpwm_irq_ctrl_if #(.PWM_WIDTH(PW), .CNT_W(CW)) bus ();

    cpwm_irq_ctrl #(
        .PWM_WIDTH (PW),
        .PULSE_LEN (PLEN),
        .CNT_W     (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .regs  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: pulses described by their start cycle, not by a counter.
    logic [PW-1:0] m_prev_in;
    logic [PW-1:0] m_status;
    logic [PW-1:0] m_ovr;
    int            m_cnt;
    logic          m_prev_mode;
    bit            m_active;
    int            m_start;
    bit            m_pend;
    bit            exp_out;
    bit            exp_busy;
    int            cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_prev_in   = '0;
        m_status    = '0;
        m_ovr       = '0;
        m_cnt       = 0;
        m_prev_mode = 1'b0;
        m_active    = 0;
        m_start     = 0;
        m_pend      = 0;
        exp_out     = 0;
        exp_busy    = 0;
    endtask

    task automatic model_eval();
        logic [PW-1:0] edg;
        logic [PW-1:0] clr;
        int            n;
        int            d;
        int            hold;
        bit            pulse;
        cyc++;
        edg       = bus.irq_en ? (bus.irq_in & ~m_prev_in) : '0;
        m_prev_in = bus.irq_in;
        clr       = bus.clr_valid ? bus.clr_mask : '0;
        m_ovr     = (m_ovr & ~clr) | (edg & m_status);
        m_status  = (m_status & ~clr) | edg;
        n         = $countones(edg);
        if (bus.cnt_clr) m_cnt = n;
        else m_cnt = (m_cnt + n > CMAX) ? CMAX : m_cnt + n;
        hold = int'(bus.holdoff);
        if (!bus.irq_en || bus.irq_mode != m_prev_mode || bus.irq_mode == 1'b0) begin
            m_active = 0;
            m_pend   = 0;
        end else if (!m_active) begin
            if (edg != '0) begin
                m_active = 1;
                m_start  = cyc;
            end
        end else begin
            d = cyc - m_start;
            if (d < PLEN + hold) begin
                if (edg != '0) m_pend = 1;
            end else if (m_pend || edg != '0) begin
                m_start = cyc;
                m_pend  = 0;
            end else begin
                m_active = 0;
            end
        end
        m_prev_mode = bus.irq_mode;
        pulse    = m_active && (cyc - m_start < PLEN);
        exp_out  = pulse || (bus.irq_mode == 1'b0 && bus.irq_en && m_status != '0);
        exp_busy = m_active;
    endtask

    task automatic compare_model();
        check("status",    32'(bus.status),    32'(m_status));
        check("overrun",   32'(bus.overrun),   32'(m_ovr));
        check("event_cnt", 32'(bus.event_cnt), 32'(m_cnt));
        check("irq_out",   32'(bus.irq_out),   32'(exp_out));
        check("irq_busy",  32'(bus.irq_busy),  32'(exp_busy));
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
        compare_model();
        bus.clr_valid = 1'b0;
        bus.cnt_clr   = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        reset         = 1'b1;
        bus.irq_in    = '0;
        bus.irq_en    = 1'b1;
        bus.irq_mode  = 1'b0;
        bus.holdoff   = 16'd3;
        bus.clr_valid = 1'b0;
        bus.clr_mask  = '0;
        bus.cnt_clr   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_status", 32'(bus.status), 32'h0);
        check("rst_ovr",    32'(bus.overrun), 32'h0);
        check("rst_cnt",    32'(bus.event_cnt), 32'h0);
        check("rst_out",    32'(bus.irq_out), 32'h0);
        check("rst_busy",   32'(bus.irq_busy), 32'h0);
        reset = 1'b0;

        // Level mode: two edges, then W1C.
        step();
        bus.irq_in = 8'h05;
        step();
        check("lvl_status", 32'(bus.status), 32'h05);
        check("lvl_cnt",    32'(bus.event_cnt), 32'h2);
        check("lvl_out",    32'(bus.irq_out), 32'h1);
        bus.clr_valid = 1'b1;
        bus.clr_mask  = 8'h05;
        step();
        check("lvl_clr_status", 32'(bus.status), 32'h00);
        check("lvl_clr_out",    32'(bus.irq_out), 32'h0);

        // Pulse mode: ch0 edge, ch1 edge during the pulse -> exactly two pulses.
        bus.irq_mode = 1'b1;
        bus.irq_in   = 8'h00;
        step();
        for (int i = 0; i < 20; i++) begin
            bus.irq_in = (i == 0) ? 8'h01 : ((i >= 2) ? 8'h03 : 8'h01);
            step();
            check("pulse_shape", 32'(bus.irq_out), 32'((i < 4) || (i >= 7 && i < 11)));
        end

        // Overrun and W1C race on ch2.
        bus.clr_valid = 1'b1;
        bus.clr_mask  = 8'hFF;
        bus.irq_in    = 8'h00;
        step();
        bus.irq_in = 8'h04;
        step();
        check("ovr_first_status", 32'(bus.status), 32'h04);
        check("ovr_first",        32'(bus.overrun), 32'h00);
        bus.irq_in = 8'h00;
        step();
        bus.irq_in = 8'h04;
        step();
        check("ovr_second", 32'(bus.overrun), 32'h04);
        bus.irq_in = 8'h00;
        step();
        bus.irq_in    = 8'h04;
        bus.clr_valid = 1'b1;
        bus.clr_mask  = 8'h04;
        step();
        check("race_status", 32'(bus.status[2]), 32'h1);
        check("race_ovr",    32'(bus.overrun[2]), 32'h1);

        // Counter saturation and clear coincident with edges.
        bus.irq_in  = 8'h00;
        bus.cnt_clr = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            bus.irq_in = 8'h01;
            step();
            bus.irq_in = 8'h00;
            step();
        end
        check("cnt_sat", 32'(bus.event_cnt), 32'(CMAX));
        bus.irq_in  = 8'h03;
        bus.cnt_clr = 1'b1;
        step();
        check("cnt_clr_edge", 32'(bus.event_cnt), 32'h2);

        // Enable gating: no edges while disabled, none on re-enable with inputs high.
        bus.irq_en    = 1'b0;
        bus.irq_in    = 8'h00;
        bus.clr_valid = 1'b1;
        bus.clr_mask  = 8'hFF;
        bus.cnt_clr   = 1'b1;
        step();
        bus.irq_in = 8'hFF;
        step();
        check("dis_status", 32'(bus.status), 32'h00);
        check("dis_cnt",    32'(bus.event_cnt), 32'h0);
        bus.irq_en = 1'b1;
        step();
        check("reen_status", 32'(bus.status), 32'h00);
        check("reen_cnt",    32'(bus.event_cnt), 32'h0);

        // Dropping irq_en during GAP.
        bus.irq_in = 8'h00;
        repeat (16) step();
        bus.irq_in = 8'h01;
        step();
        check("gap_start_out", 32'(bus.irq_out), 32'h1);
        repeat (4) step();
        check("gap_busy", 32'(bus.irq_busy), 32'h1);
        check("gap_out",  32'(bus.irq_out), 32'h0);
        bus.irq_en = 1'b0;
        step();
        check("gap_dis_busy", 32'(bus.irq_busy), 32'h0);

        // Asynchronous reset in the middle of a pulse.
        bus.irq_en = 1'b1;
        bus.irq_in = 8'h00;
        repeat (2) step();
        bus.irq_in = 8'h02;
        step();
        step();
        check("mid_pulse_out", 32'(bus.irq_out), 32'h1);
        reset = 1'b1;
        #1;
        check("arst_out",    32'(bus.irq_out), 32'h0);
        check("arst_status", 32'(bus.status), 32'h0);
        check("arst_cnt",    32'(bus.event_cnt), 32'h0);
        check("arst_busy",   32'(bus.irq_busy), 32'h0);
        model_reset();
        bus.irq_in = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("post_rst_out", 32'(bus.irq_out), 32'h0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if (i % 200 == 0) begin
                bus.irq_en  = 1'b0;
                bus.holdoff = 16'($urandom_range(0, 5));
                step();
            end
            bus.irq_in    = bus.irq_in ^ (8'($urandom) & 8'($urandom));
            bus.irq_en    = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 99) == 0) bus.irq_mode = ~bus.irq_mode;
            bus.clr_valid = ($urandom_range(0, 7) == 0);
            bus.clr_mask  = 8'($urandom);
            bus.cnt_clr   = ($urandom_range(0, 31) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
